note_sequencer: RTL and testbench

- Parametrised successor to the single-mode guitar recorder. It records fretboard input (strings × frets) into an internal note memory, one word per beat.
- It plays the memory back at a programmable tempo, with optional looping, explicit stop, full detection and recorded-length tracking.
- It sits between the GPIO fretboard inputs and the audio/note output stage, driven by the top-level mode/select control.

---
 rtl/note_seq_pkg.sv | 13 +
 rtl/note_seq_beat.sv | 37 +++
 rtl/note_sequencer.sv | 145 ++++++++++++++
 tb/tb_note_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: FSM encodings and note-word sizing.
package note_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

  // One string slice per fret position, open position included.
  function automatic int note_width(input int num_strings, input int num_frets);
    return num_strings * (num_frets + 1);
  endfunction

endpackage

// File: rtl/note_seq_beat.sv
// Programmable beat divider: one tick every period clocks while enabled, idle at zero otherwise.
module beat_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] reload_next;

  // Periods below two would tick continuously or never; clamp to two.
  assign reload_next = (period < CNT_W'(2)) ? CNT_W'(1) : period - CNT_W'(1);
  assign tick        = enable && (count == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= reload_next;
      reload <= reload_next;
    end else if (!enable) begin
      count <= '0;
    end else if (count == '0) begin
      count <= reload;
    end else begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Records fretboard activity into a note memory one word per beat and plays it back at a set tempo.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int NUM_STRINGS = 6,
  parameter int NUM_FRETS   = 4,
  parameter int DEPTH       = 64,
  parameter int CNT_W       = 27,
  localparam int NOTE_W     = note_width(NUM_STRINGS, NUM_FRETS),
  localparam int LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [CNT_W-1:0]       beat_period,
  input  logic [NUM_STRINGS-1:0] strings,
  input  logic [NUM_FRETS-1:0]   frets,
  output logic [NOTE_W-1:0]      note_out,
  output logic                   note_valid,
  output logic                   beat_tick,
  output logic                   busy,
  output logic                   full,
  output logic [LEN_W-1:0]       len,
  output logic [1:0]             state
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [NOTE_W-1:0] acc;
  logic [NOTE_W-1:0] sample;
  logic [NOTE_W-1:0] word;
  logic [NOTE_W-1:0] mem [DEPTH];
  logic              tick;
  logic              rec_go;
  logic              play_go;
  logic              mem_we;
  logic              last_rd;
  logic              fill_now;
  int                pos;

  // Highest pressed fret wins; the strings land in that fret's slice.
  always_comb begin
    pos = 0;
    for (int f = 0; f < NUM_FRETS; f++) begin
      if (frets[f]) pos = f + 1;
    end
    sample = '0;
    for (int p = 0; p <= NUM_FRETS; p++) begin
      if (pos == p) sample[p*NUM_STRINGS +: NUM_STRINGS] = strings;
    end
  end

  assign word      = acc | sample;
  assign busy      = (state == S_REC) || (state == S_PLAY);
  assign rec_go    = (state == S_IDLE) && start && !stop && mode;
  assign play_go   = (state == S_IDLE) && start && !stop && !mode && (len != '0);
  assign mem_we    = (state == S_REC) && tick;
  assign last_rd   = (LEN_W'(rd_addr) + LEN_W'(1)) == len;
  assign fill_now  = len == LEN_W'(DEPTH - 1);
  assign beat_tick = tick;

  beat_timer #(.CNT_W(CNT_W)) u_beat_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (rec_go || play_go),
    .enable (busy),
    .period (beat_period),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      len        <= '0;
      full       <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      acc        <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rec_go) begin
            state   <= S_REC;
            len     <= '0;
            full    <= 1'b0;
            wr_addr <= '0;
            acc     <= '0;
          end else if (play_go) begin
            state   <= S_PLAY;
            rd_addr <= '0;
          end
        end
        S_REC: begin
          if (tick) begin
            wr_addr <= wr_addr + AW'(1);
            len     <= len + LEN_W'(1);
            acc     <= '0;
            if (fill_now) begin
              full  <= 1'b1;
              state <= S_IDLE;
            end else if (stop) begin
              state <= S_IDLE;
            end
          end else if (stop) begin
            acc   <= '0;
            state <= S_IDLE;
          end else begin
            acc <= word;
          end
        end
        S_PLAY: begin
          // A stop landing on a beat still lets that beat's note out.
          if (tick) begin
            note_out   <= mem[rd_addr];
            note_valid <= 1'b1;
            if (last_rd) begin
              rd_addr <= '0;
              if (!loop_en) state <= S_IDLE;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
            if (stop) state <= S_IDLE;
          end else if (stop) begin
            note_out <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a four-word memory and short beat periods.
module tb_note_sequencer;

  localparam int NS     = 6;
  localparam int NF     = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int NOTE_W = 30;
  localparam int LEN_W  = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              mode;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [CNT_W-1:0]  beat_period;
  logic [NS-1:0]     strings;
  logic [NF-1:0]     frets;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic              beat_tick;
  logic              busy;
  logic              full;
  logic [LEN_W-1:0]  len;
  logic [1:0]        state;

  int passed = 0;
  int total  = 0;

  note_sequencer #(
    .NUM_STRINGS(NS), .NUM_FRETS(NF), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .start(start), .stop(stop),
    .loop_en(loop_en), .beat_period(beat_period), .strings(strings), .frets(frets),
    .note_out(note_out), .note_valid(note_valid), .beat_tick(beat_tick),
    .busy(busy), .full(full), .len(len), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic m, input logic [CNT_W-1:0] p);
    mode        = m;
    beat_period = p;
    start       = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; mode = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    beat_period = '0; strings = '0; frets = '0;
    step(); step();
    total++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
    total++; if (len !== 3'd0) $display("FAIL reset_len got=%0d exp=0", len); else passed++;
    total++; if ({note_valid, beat_tick, busy, full} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {note_valid, beat_tick, busy, full}); else passed++;
    total++; if (note_out !== '0) $display("FAIL reset_note got=%h exp=0", note_out); else passed++;
    #2 resetn = 1'b1;
    step();
  endtask

  task automatic test_idle_edges();
    pulse_start(1'b0, 8'd4);
    step(); step(); step();
    total++; if ({busy, state} !== 3'b000)
      $display("FAIL play_empty got=%b exp=000", {busy, state}); else passed++;
    mode = 1'b1; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    total++; if (state !== 2'd0) $display("FAIL start_stop_state got=%0d exp=0", state); else passed++;
    total++; if (beat_tick !== 1'b0) $display("FAIL start_stop_tick got=%b exp=0", beat_tick); else passed++;
  endtask

  task automatic test_reset_mid_rec();
    strings = 6'b000001; frets = '0;
    pulse_start(1'b1, 8'd4);
    for (int c = 1; c <= 4; c++) step();
    total++; if (len !== 3'd1) $display("FAIL midrec_pre_len got=%0d exp=1", len); else passed++;
    #2 resetn = 1'b0;
    #1;
    total++; if (state !== 2'd0) $display("FAIL midrec_state got=%0d exp=0", state); else passed++;
    total++; if (len !== 3'd0) $display("FAIL midrec_len got=%0d exp=0", len); else passed++;
    total++; if ({note_valid, beat_tick, busy, full, note_out} !== '0)
      $display("FAIL midrec_outputs got=%b_%h exp=0", {note_valid, beat_tick, busy, full}, note_out); else passed++;
    #1 resetn = 1'b1;
    strings = '0;
    step();
  endtask

  task automatic test_record();
    logic [15:0] tmask;
    tmask = '0;
    strings = 6'b000001; frets = '0;
    pulse_start(1'b1, 8'd4);
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) begin strings = 6'b000010; frets = 4'b0011; end
      if (c == 9) stop = 1'b1;
      tmask[c] = beat_tick;
      step();
    end
    stop = 1'b0; strings = '0; frets = '0;
    total++; if (tmask !== 16'h0110) $display("FAIL rec_ticks got=%h exp=0110", tmask); else passed++;
    total++; if (len !== 3'd2) $display("FAIL rec_len got=%0d exp=2", len); else passed++;
    total++; if (state !== 2'd0) $display("FAIL rec_stop_state got=%0d exp=0", state); else passed++;
  endtask

  task automatic test_play();
    logic [15:0]       vmask;
    logic [NOTE_W-1:0] w [2];
    int                n;
    vmask = '0; n = 0;
    w[0] = '0; w[1] = '0;
    loop_en = 1'b0;
    pulse_start(1'b0, 8'd4);
    for (int c = 1; c <= 11; c++) begin
      if (c == 2) begin
        total++; if (state !== 2'd2) $display("FAIL play_state got=%0d exp=2", state); else passed++;
      end
      vmask[c] = note_valid;
      if (note_valid && n < 2) begin w[n] = note_out; n++; end
      step();
    end
    total++; if (vmask !== 16'h0220) $display("FAIL play_valid got=%h exp=0220", vmask); else passed++;
    total++; if (w[0] !== 30'h0000_0001) $display("FAIL play_word0 got=%h exp=00000001", w[0]); else passed++;
    total++; if (w[1] !== 30'h0000_2000) $display("FAIL play_word1 got=%h exp=00002000", w[1]); else passed++;
    total++; if (state !== 2'd0) $display("FAIL play_end_state got=%0d exp=0", state); else passed++;
    total++; if (note_out !== 30'h0000_2000) $display("FAIL play_hold got=%h exp=00002000", note_out); else passed++;
  endtask

  task automatic test_full();
    logic [15:0] tmask;
    tmask = '0;
    strings = '0; frets = '0;
    pulse_start(1'b1, 8'd3);
    for (int c = 1; c <= 14; c++) begin
      if (c == 1 || c == 4 || c == 7 || c == 10) strings = NS'((c + 2) / 3);
      tmask[c] = beat_tick;
      step();
    end
    strings = '0;
    total++; if (tmask !== 16'h1248) $display("FAIL full_ticks got=%h exp=1248", tmask); else passed++;
    total++; if (full !== 1'b1) $display("FAIL full_flag got=%b exp=1", full); else passed++;
    total++; if (len !== 3'd4) $display("FAIL full_len got=%0d exp=4", len); else passed++;
    total++; if (state !== 2'd0) $display("FAIL full_state got=%0d exp=0", state); else passed++;
  endtask

  task automatic test_loop();
    logic [15:0]       vmask;
    logic [NOTE_W-1:0] w [8];
    int                n;
    vmask = '0; n = 0;
    for (int i = 0; i < 8; i++) w[i] = '0;
    loop_en = 1'b1;
    pulse_start(1'b0, 8'd2);
    for (int c = 1; c <= 14; c++) begin
      stop = (c == 10);
      vmask[c] = note_valid;
      if (note_valid && n < 8) begin w[n] = note_out; n++; end
      step();
    end
    stop = 1'b0; loop_en = 1'b0;
    total++; if (vmask !== 16'h0AA8) $display("FAIL loop_valid got=%h exp=0aa8", vmask); else passed++;
    total++; if ({w[0], w[1], w[2], w[3], w[4]} !== {30'd1, 30'd2, 30'd3, 30'd4, 30'd1})
      $display("FAIL loop_words got=%0d,%0d,%0d,%0d,%0d exp=1,2,3,4,1", w[0], w[1], w[2], w[3], w[4]);
    else passed++;
    total++; if (state !== 2'd0) $display("FAIL loop_stop_state got=%0d exp=0", state); else passed++;
    total++; if (note_out !== 30'd1) $display("FAIL loop_hold got=%h exp=00000001", note_out); else passed++;
  endtask

  task automatic test_stop_play();
    logic [15:0] vmask;
    vmask = '0;
    pulse_start(1'b0, 8'd4);
    for (int c = 1; c <= 12; c++) begin
      stop = (c == 6);
      if (c == 5) begin
        total++; if (note_out !== 30'd1) $display("FAIL stop_pre_note got=%h exp=00000001", note_out); else passed++;
      end
      if (c == 7) begin
        total++; if (note_out !== '0) $display("FAIL stop_note_clear got=%h exp=0", note_out); else passed++;
        total++; if (state !== 2'd0) $display("FAIL stop_state got=%0d exp=0", state); else passed++;
      end
      vmask[c] = note_valid;
      step();
    end
    stop = 1'b0;
    total++; if (vmask !== 16'h0020) $display("FAIL stop_valid got=%h exp=0020", vmask); else passed++;
  endtask

  task automatic test_period_zero();
    logic [15:0] tmask;
    tmask = '0;
    strings = '0; frets = '0;
    pulse_start(1'b1, 8'd0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin start = 1'b1; mode = 1'b0; end
      if (c == 4) start = 1'b0;
      if (c == 5) begin
        total++; if (state !== 2'd1) $display("FAIL busy_start_state got=%0d exp=1", state); else passed++;
      end
      stop = (c == 7);
      tmask[c] = beat_tick;
      step();
    end
    stop = 1'b0;
    total++; if (tmask !== 16'h0054) $display("FAIL p0_ticks got=%h exp=0054", tmask); else passed++;
    total++; if (len !== 3'd3) $display("FAIL p0_len got=%0d exp=3", len); else passed++;
    total++; if (full !== 1'b0) $display("FAIL p0_full got=%b exp=0", full); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_edges();
    test_reset_mid_rec();
    test_record();
    test_play();
    test_full();
    test_loop();
    test_stop_play();
    test_period_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
